disp_arbiter: RTL and testbench

- Scheduler that shares the single four-digit seven-segment display between NREQ requesters (e.g. level/score, countdown timer, status message).
- Grants one owner at a time, enforces a minimum on-screen hold time, and handles priority preemption.
- Drives the selected 16-bit hex value plus a blank/blink control into the digit-multiplexing scan machine downstream.

---
 rtl/disp_arbiter_pkg.sv | 19 +
 rtl/disp_arbiter_if.sv | 27 ++
 rtl/disp_arbiter_prescaler.sv | 23 ++
 rtl/disp_arbiter.sv | 117 +++++++++++
 tb/tb_disp_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/disp_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter and its scan path.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } disp_state_e;

  localparam int DISP_DIGITS = 4;
  localparam int FREE_W      = 25;
  localparam int MAX_REQ     = 32;

  // Isolates the lowest set bit: index 0 is the highest-priority requester.
  function automatic logic [MAX_REQ-1:0] prio_onehot(input logic [MAX_REQ-1:0] r);
    return r & (~r + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester-facing bundle of the display arbiter: requests/values in, grant and display data out.
interface disp_arbiter_if
  import disp_pkg::*;
#(
  parameter int NREQ = 3
);
  localparam int DW = 4 * DISP_DIGITS;

  logic [NREQ-1:0]    req;
  logic [DW*NREQ-1:0] val;
  logic [NREQ-1:0]    blink;
  logic [NREQ-1:0]    grant;
  logic [DW-1:0]      disp_val;
  logic               disp_blank;
  logic               busy;

  modport master (
    output req, val, blink,
    input  grant, disp_val, disp_blank, busy
  );

  modport slave (
    input  req, val, blink,
    output grant, disp_val, disp_blank, busy
  );

endinterface

// File: rtl/disp_arbiter_prescaler.sv
// Free-running counter giving the hold tick and blink phase; shared with the digit scan machine.
module disp_prescaler #(
  parameter int CNT_W     = 25,
  parameter int TICK_W    = 16,
  parameter int BLINK_BIT = 24
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic blink_phase
);

  logic [CNT_W-1:0] free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) free <= '0;
    else        free <= free + CNT_W'(1);
  end

  assign tick        = &free[TICK_W-1:0];
  assign blink_phase = free[BLINK_BIT];

endmodule

// File: rtl/disp_arbiter.sv
// Priority arbiter sharing one four-digit display among NREQ requesters with a minimum hold time.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int TICK_W     = 16,
  parameter int HOLD_TICKS = 8,
  parameter int BLINK_BIT  = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  disp_arbiter_if.slave  bus
);

  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);

  disp_state_e     state, state_n;
  logic [NREQ-1:0] grant_q, grant_n;
  logic [HW-1:0]   hold_cnt, hold_n, hold_dec;
  logic [NREQ-1:0] win;
  logic            higher, owner_req, own_blink;
  logic            tick, blink_phase;
  logic [15:0]     sel_val;
  logic [15:0]     disp_val_q;
  logic            disp_blank_q;

  disp_prescaler #(
    .CNT_W     (FREE_W),
    .TICK_W    (TICK_W),
    .BLINK_BIT (BLINK_BIT)
  ) u_prescaler (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .blink_phase (blink_phase)
  );

  assign win       = NREQ'(prio_onehot(MAX_REQ'(bus.req)));
  // Bits below the owner's one-hot position are exactly the higher-priority requesters.
  assign higher    = |(bus.req & (grant_q - NREQ'(1)));
  assign owner_req = |(bus.req & grant_q);
  assign hold_dec  = (tick && hold_cnt != '0) ? hold_cnt - HW'(1) : hold_cnt;

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_n = win;
          hold_n  = HOLD_INIT;
          state_n = HOLD;
        end
      end
      HOLD: begin
        hold_n = hold_dec;
        if (hold_dec == '0) state_n = OPEN;
      end
      OPEN: begin
        if (higher || !owner_req) begin
          if (|bus.req) begin
            grant_n = win;
            hold_n  = HOLD_INIT;
            state_n = HOLD;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant_q  <= grant_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) sel_val = sel_val | bus.val[16*i +: 16];
    end
  end

  assign own_blink = |(bus.blink & grant_q);

  // Display stage: one cycle behind the grant so the owner's value tracks live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val_q   <= '0;
      disp_blank_q <= 1'b1;
    end else begin
      if (state != IDLE) disp_val_q <= sel_val;
      disp_blank_q <= (state == IDLE) | (own_blink & blink_phase);
    end
  end

  assign bus.grant      = grant_q;
  assign bus.disp_val   = disp_val_q;
  assign bus.disp_blank = disp_blank_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter built with a fast tick (TICK_W=2), HOLD_TICKS=2 and BLINK_BIT=4.
module tb_disp_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   ecnt;

  disp_arbiter_if #(.NREQ(3)) bus ();

  disp_arbiter #(
    .NREQ       (3),
    .TICK_W     (2),
    .HOLD_TICKS (2),
    .BLINK_BIT  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; equals the free-running counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    while (ecnt < t) @(negedge clk);
    if (ecnt != t) begin
      $display("FAIL goto observed=%0d expected=%0d", ecnt, t);
      $fatal(1, "bench lost cycle alignment");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req   = 3'b000;
    bus.val   = '0;
    bus.blink = 3'b000;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_blank", 32'(bus.disp_blank), 32'h1);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_val", 32'(bus.disp_val), 32'h0);
    end
    rst_n = 1'b1;

    // Single grant, req dropped after the first tick
    bus.req = 3'b010;
    bus.val[31:16] = 16'h0300;
    goto(1);
    chk("g1_grant", 32'(bus.grant), 32'h2);
    chk("g1_busy", 32'(bus.busy), 32'h1);
    chk("g1_blank", 32'(bus.disp_blank), 32'h1);
    goto(2);
    chk("g1_val", 32'(bus.disp_val), 32'h0300);
    chk("g1_blank2", 32'(bus.disp_blank), 32'h0);
    goto(5);
    bus.req = 3'b000;
    goto(7);
    chk("g1_hold", 32'(bus.grant), 32'h2);
    goto(8);
    chk("g1_open", 32'(bus.grant), 32'h2);
    goto(9);
    chk("g1_idle_grant", 32'(bus.grant), 32'h0);
    chk("g1_idle_busy", 32'(bus.busy), 32'h0);
    goto(10);
    chk("g1_idle_blank", 32'(bus.disp_blank), 32'h1);
    chk("g1_idle_val", 32'(bus.disp_val), 32'h0300);

    // Owner 2, then requester 0 arrives during hold and preempts once open
    bus.req = 3'b100;
    bus.val[47:32] = 16'hABCD;
    goto(11);
    chk("p_grant2", 32'(bus.grant), 32'h4);
    goto(13);
    bus.req = 3'b101;
    bus.val[15:0] = 16'h1234;
    goto(14);
    chk("p_hold_ignore", 32'(bus.grant), 32'h4);
    goto(16);
    chk("p_open_owner2", 32'(bus.grant), 32'h4);
    goto(17);
    chk("p_preempt", 32'(bus.grant), 32'h1);
    chk("p_val_lag", 32'(bus.disp_val), 32'hABCD);
    goto(18);
    chk("p_val0", 32'(bus.disp_val), 32'h1234);
    goto(25);
    chk("p_low_no_preempt", 32'(bus.grant), 32'h1);
    chk("p_busy", 32'(bus.busy), 32'h1);

    // Handover 0 -> 1 -> 2 with no blank cycle, then release to idle
    bus.req = 3'b110;
    bus.val[31:16] = 16'h5678;
    goto(26);
    chk("h_grant1", 32'(bus.grant), 32'h2);
    chk("h_blank1", 32'(bus.disp_blank), 32'h0);
    goto(27);
    chk("h_val1", 32'(bus.disp_val), 32'h5678);
    goto(32);
    bus.req = 3'b100;
    goto(33);
    chk("h_grant2", 32'(bus.grant), 32'h4);
    chk("h_blank2", 32'(bus.disp_blank), 32'h0);
    goto(34);
    chk("h_val2", 32'(bus.disp_val), 32'hABCD);
    bus.val[47:32] = 16'h4321;
    goto(35);
    chk("h_val_live", 32'(bus.disp_val), 32'h4321);
    goto(40);
    bus.req = 3'b000;
    goto(41);
    chk("h_idle_grant", 32'(bus.grant), 32'h0);
    chk("h_idle_busy", 32'(bus.busy), 32'h0);
    goto(42);
    chk("h_idle_blank", 32'(bus.disp_blank), 32'h1);
    chk("h_idle_val", 32'(bus.disp_val), 32'h4321);

    // Blink follows bit 4 of the free counter as it stood before each edge
    bus.req = 3'b001;
    bus.blink = 3'b001;
    goto(43);
    chk("b_grant", 32'(bus.grant), 32'h1);
    for (int e = 44; e <= 75; e++) begin
      goto(e);
      chk("b_phase", 32'(bus.disp_blank), 32'(((e - 1) >> 4) & 1));
    end
    goto(76);
    bus.blink = 3'b000;
    for (int e = 77; e <= 80; e++) begin
      goto(e);
      chk("b_steady", 32'(bus.disp_blank), 32'h0);
    end

    // Asynchronous reset in the middle of a hold
    bus.req = 3'b010;
    goto(81);
    chk("r_grant_pre", 32'(bus.grant), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_grant", 32'(bus.grant), 32'h0);
    chk("r_async_blank", 32'(bus.disp_blank), 32'h1);
    chk("r_async_busy", 32'(bus.busy), 32'h0);
    chk("r_async_val", 32'(bus.disp_val), 32'h0);
    @(negedge clk);
    chk("r_held_grant", 32'(bus.grant), 32'h0);
    rst_n = 1'b1;
    goto(1);
    chk("r_restart_grant", 32'(bus.grant), 32'h2);
    chk("r_restart_busy", 32'(bus.busy), 32'h1);
    goto(2);
    chk("r_restart_val", 32'(bus.disp_val), 32'h5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
